// File: rtl/memory_stage.sv
// MEM pipeline stage: passthrough retire or load/store over a req/ack bus, stalling EXECUTE while busy.
// Optional bus timeout enabled by defining MEM_STAGE_TIMEOUT_EN (reports mem_err on the retire).
module memory_stage #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 16,
  parameter int RD_W        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] ST_reg_out,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              wb_en_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [RD_W-1:0]   rd_out,
  output logic              wb_en_out,
  output logic              mem_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   mem_result_q, mem_result_d;
  logic [RD_W-1:0]     rd_out_q, rd_out_d;
  logic                wb_en_out_q, wb_en_out_d;
  logic                mem_err_q, mem_err_d;
  // Destination info of the in-flight memory op, applied when it retires
  logic [RD_W-1:0]     rd_pend_q, rd_pend_d;
  logic                wb_en_pend_q, wb_en_pend_d;
  logic                accept_s;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
`endif

  assign ex_ready = (state_q == IDLE);
  assign accept_s = ex_valid && ex_ready;

  // Next-state and next-output computation for the IDLE/BUS controller
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    wb_valid_d   = 1'b0;
    mem_result_d = mem_result_q;
    rd_out_d     = rd_out_q;
    wb_en_out_d  = 1'b0;
    mem_err_d    = 1'b0;
    rd_pend_d    = rd_pend_q;
    wb_en_pend_d = wb_en_pend_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (mem_read || mem_write) begin
            state_d      = BUS;
            bus_req_d    = 1'b1;
            bus_we_d     = mem_write;
            bus_addr_d   = alu_result[ADDR_W-1:0];
            bus_wdata_d  = ST_reg_out;
            rd_pend_d    = rd_in;
            wb_en_pend_d = wb_en_in;
`ifdef MEM_STAGE_TIMEOUT_EN
            to_cnt_d     = {CNT_W{1'b0}};
`endif
          end else begin
            wb_valid_d   = 1'b1;
            mem_result_d = alu_result;
            rd_out_d     = rd_in;
            wb_en_out_d  = wb_en_in;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          rd_out_d   = rd_pend_q;
          if (!bus_we_q) begin
            mem_result_d = bus_rdata;
            wb_en_out_d  = wb_en_pend_q;
          end else begin
            wb_en_out_d  = 1'b0;
          end
        end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
          // Limit edge reached without ack: abandon the access and retire with an error
          if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d      = IDLE;
            bus_req_d    = 1'b0;
            wb_valid_d   = 1'b1;
            rd_out_d     = rd_pend_q;
            mem_result_d = {DATA_W{1'b0}};
            mem_err_d    = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
          end
`else
          state_d = BUS;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
      wb_valid_q   <= 1'b0;
      mem_result_q <= {DATA_W{1'b0}};
      rd_out_q     <= {RD_W{1'b0}};
      wb_en_out_q  <= 1'b0;
      mem_err_q    <= 1'b0;
      rd_pend_q    <= {RD_W{1'b0}};
      wb_en_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      mem_result_q <= mem_result_d;
      rd_out_q     <= rd_out_d;
      wb_en_out_q  <= wb_en_out_d;
      mem_err_q    <= mem_err_d;
      rd_pend_q    <= rd_pend_d;
      wb_en_pend_q <= wb_en_pend_d;
    end
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  // Bus wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= {CNT_W{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign mem_result = mem_result_q;
  assign rd_out     = rd_out_q;
  assign wb_en_out  = wb_en_out_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT_CYC=4; timeout case when MEM_STAGE_TIMEOUT_EN is defined).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, mem_read, mem_write;
  logic [23:0] alu_result, st_reg_out;
  logic [3:0]  rd_in, rd_out;
  logic        wb_en_in, bus_req, bus_we, bus_ack, wb_valid, wb_en_out, mem_err;
  logic [15:0] bus_addr;
  logic [23:0] bus_wdata, bus_rdata, mem_result;

  int checks = 0;
  int failures = 0;

  memory_stage #(.DATA_W(24), .ADDR_W(16), .RD_W(4), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .alu_result(alu_result),
    .ST_reg_out(st_reg_out), .rd_in(rd_in), .wb_en_in(wb_en_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
    .mem_result(mem_result), .rd_out(rd_out), .wb_en_out(wb_en_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = 24'd0; st_reg_out = 24'd0; rd_in = 4'd0; wb_en_in = 1'b0;
    bus_ack = 1'b0; bus_rdata = 24'd0;
    #12;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mem_result", {8'd0, mem_result}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: passthrough
    ex_valid = 1'b1; alu_result = 24'd15; rd_in = 4'd3; wb_en_in = 1'b1;
    tick();
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_mem_result", {8'd0, mem_result}, 32'd15);
    chk("add_rd_out", {28'd0, rd_out}, 32'd3);
    chk("add_wb_en_out", {31'd0, wb_en_out}, 32'd1);
    chk("add_ex_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b0;
    tick();
    chk("add_wb_valid_drop", {31'd0, wb_valid}, 32'd0);
    chk("add_mem_result_hold", {8'd0, mem_result}, 32'd15);

    // 2: load, ack in third bus cycle
    ex_valid = 1'b1; mem_read = 1'b1; alu_result = 24'h000040; rd_in = 4'd5; wb_en_in = 1'b1;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0; alu_result = 24'h111111;
    for (int i = 0; i < 3; i++) begin
      chk("ld_bus_req", {31'd0, bus_req}, 32'd1);
      chk("ld_bus_addr", {16'd0, bus_addr}, 32'h40);
      chk("ld_bus_we", {31'd0, bus_we}, 32'd0);
      chk("ld_ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("ld_wb_valid_busy", {31'd0, wb_valid}, 32'd0);
      if (i == 2) begin
        bus_ack = 1'b1; bus_rdata = 24'hABCDEF;
      end
      tick();
    end
    bus_ack = 1'b0; bus_rdata = 24'h0;
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_mem_result", {8'd0, mem_result}, 32'hABCDEF);
    chk("ld_rd_out", {28'd0, rd_out}, 32'd5);
    chk("ld_wb_en_out", {31'd0, wb_en_out}, 32'd1);
    chk("ld_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("ld_ex_ready_back", {31'd0, ex_ready}, 32'd1);

    // Stray ack while idle must be ignored
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("stray_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("stray_ack_bus_req", {31'd0, bus_req}, 32'd0);

    // 3: store (read+write both set -> store), immediate ack
    ex_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b1; alu_result = 24'h000010;
    st_reg_out = 24'd5; rd_in = 4'd7; wb_en_in = 1'b1;
    tick();
    ex_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    chk("st_bus_req", {31'd0, bus_req}, 32'd1);
    chk("st_bus_we", {31'd0, bus_we}, 32'd1);
    chk("st_bus_wdata", {8'd0, bus_wdata}, 32'd5);
    chk("st_bus_addr", {16'd0, bus_addr}, 32'h10);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("st_mem_result_hold", {8'd0, mem_result}, 32'hABCDEF);
    chk("st_bus_req_drop", {31'd0, bus_req}, 32'd0);

    // 4: back-to-back passthrough
    ex_valid = 1'b1; wb_en_in = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      alu_result = 24'(v); rd_in = 4'(v + 8);
      tick();
      chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("b2b_mem_result", {8'd0, mem_result}, 32'(v));
      chk("b2b_rd_out", {28'd0, rd_out}, 32'(v + 8));
    end
    ex_valid = 1'b0;
    tick();
    chk("b2b_wb_valid_end", {31'd0, wb_valid}, 32'd0);

    // 5: reset during bus wait
    ex_valid = 1'b1; mem_read = 1'b1; alu_result = 24'h000123;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    chk("rstmid_bus_req_pre", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstmid_ex_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_ex_ready_after", {31'd0, ex_ready}, 32'd1);
    chk("rstmid_wb_valid_after", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // 6: timeout after 4 bus cycles without ack
    ex_valid = 1'b1; mem_read = 1'b1; alu_result = 24'h000077; rd_in = 4'd2; wb_en_in = 1'b1;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_bus_req", {31'd0, bus_req}, 32'd1);
      tick();
    end
    chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_mem_err", {31'd0, mem_err}, 32'd1);
    chk("to_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("to_mem_result", {8'd0, mem_result}, 32'd0);
`else
    // Without timeout the bus waits indefinitely, then retires normally
    ex_valid = 1'b1; mem_read = 1'b1; alu_result = 24'h000077; rd_in = 4'd2; wb_en_in = 1'b1;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("wait_bus_req", {31'd0, bus_req}, 32'd1);
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 24'h123456;
    tick();
    bus_ack = 1'b0;
    chk("wait_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wait_mem_err", {31'd0, mem_err}, 32'd0);
    chk("wait_mem_result", {8'd0, mem_result}, 32'h123456);
    chk("wait_rd_out", {28'd0, rd_out}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
